// File: rtl/tap_controller_if.sv
// ----------------------------------------------------------------------------
// tap_controller_if
// Bundles the JTAG TAP controller's serial-path and state-decode signals.
// tck and trst stay plain ports on the controller.
//
//   tms        test mode select, sampled by the controller on rising tck
//   tdo_ir     serial out of the instruction register
//   tdo_dr     serial out of the selected data register
//   state      current TAP state (IEEE 1149.1 4-bit encoding)
//   tl_reset   active-low test-logic reset to the IR and DRs
//   captureIR/shiftIR/captureDR/shiftDR   state-decode levels
//   updateIR/updateDR                     glitch-free update strobes
//   tck_ir/tck_dr                         gated tck for the shift chains
//   select     1 = IR path, 0 = DR path
//   tdo/tdo_en retimed serial out and its output enable
//
// master: the TAP controller.  slave: the register / pad side.
// ----------------------------------------------------------------------------
interface tap_controller_if;
    logic       tms;
    logic       tdo_ir;
    logic       tdo_dr;
    logic [3:0] state;
    logic       tl_reset;
    logic       captureIR;
    logic       shiftIR;
    logic       captureDR;
    logic       shiftDR;
    logic       updateIR;
    logic       updateDR;
    logic       tck_ir;
    logic       tck_dr;
    logic       select;
    logic       tdo;
    logic       tdo_en;

    modport master (
        input  tms, tdo_ir, tdo_dr,
        output state, tl_reset, captureIR, shiftIR, captureDR, shiftDR,
               updateIR, updateDR, tck_ir, tck_dr, select, tdo, tdo_en
    );

    modport slave (
        output tms, tdo_ir, tdo_dr,
        input  state, tl_reset, captureIR, shiftIR, captureDR, shiftDR,
               updateIR, updateDR, tck_ir, tck_dr, select, tdo, tdo_en
    );
endinterface

// File: rtl/tap_controller.sv
// ----------------------------------------------------------------------------
// tap_controller
// IEEE 1149.1 TAP state machine with falling-edge retimed update strobes,
// gated shift clocks and serial-out register.
//
//   tck   test clock; FSM advances on rising edge, outputs retimed on falling
//   trst  asynchronous active-low reset (forces Test-Logic-Reset)
//   bus   tap_controller_if.master (tms, tdo_ir, tdo_dr in; decodes,
//         strobes, gated clocks, tdo/tdo_en out)
// ----------------------------------------------------------------------------
module tap_controller (
    input  logic              tck,
    input  logic              trst,
    tap_controller_if.master  bus
);

    typedef enum logic [3:0] {
        EXIT2_DR   = 4'h0,
        EXIT1_DR   = 4'h1,
        SHIFT_DR   = 4'h2,
        PAUSE_DR   = 4'h3,
        SELECT_IR  = 4'h4,
        UPDATE_DR  = 4'h5,
        CAPTURE_DR = 4'h6,
        SELECT_DR  = 4'h7,
        EXIT2_IR   = 4'h8,
        EXIT1_IR   = 4'h9,
        SHIFT_IR   = 4'hA,
        PAUSE_IR   = 4'hB,
        RUN_IDLE   = 4'hC,
        UPDATE_IR  = 4'hD,
        CAPTURE_IR = 4'hE,
        TLR        = 4'hF
    } tap_state_t;

    tap_state_t cur;

    logic sel;
    logic update_ir_q;
    logic update_dr_q;
    logic ir_en;
    logic dr_en;
    logic tdo_q;
    logic tdo_en_q;

    // ------------------------------------------------------------------
    // State register: rising tck
    // ------------------------------------------------------------------
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            cur <= TLR;
        end else begin
            case (cur)
                TLR:        cur <= bus.tms ? TLR        : RUN_IDLE;
                RUN_IDLE:   cur <= bus.tms ? SELECT_DR  : RUN_IDLE;
                SELECT_DR:  cur <= bus.tms ? SELECT_IR  : CAPTURE_DR;
                SELECT_IR:  cur <= bus.tms ? TLR        : CAPTURE_IR;
                CAPTURE_DR: cur <= bus.tms ? EXIT1_DR   : SHIFT_DR;
                SHIFT_DR:   cur <= bus.tms ? EXIT1_DR   : SHIFT_DR;
                EXIT1_DR:   cur <= bus.tms ? UPDATE_DR  : PAUSE_DR;
                PAUSE_DR:   cur <= bus.tms ? EXIT2_DR   : PAUSE_DR;
                EXIT2_DR:   cur <= bus.tms ? UPDATE_DR  : SHIFT_DR;
                UPDATE_DR:  cur <= bus.tms ? SELECT_DR  : RUN_IDLE;
                CAPTURE_IR: cur <= bus.tms ? EXIT1_IR   : SHIFT_IR;
                SHIFT_IR:   cur <= bus.tms ? EXIT1_IR   : SHIFT_IR;
                EXIT1_IR:   cur <= bus.tms ? UPDATE_IR  : PAUSE_IR;
                PAUSE_IR:   cur <= bus.tms ? EXIT2_IR   : PAUSE_IR;
                EXIT2_IR:   cur <= bus.tms ? UPDATE_IR  : SHIFT_IR;
                UPDATE_IR:  cur <= bus.tms ? SELECT_DR  : RUN_IDLE;
                default:    cur <= TLR;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Path select: IR side of the diagram (Select-IR through Update-IR)
    // ------------------------------------------------------------------
    always_comb begin
        sel = 1'b0;
        case (cur)
            SELECT_IR, EXIT2_IR, EXIT1_IR, SHIFT_IR,
            PAUSE_IR, UPDATE_IR, CAPTURE_IR: sel = 1'b1;
            default:                         sel = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Falling-edge retiming. Enables only change while tck is low, so the
    // AND-gated shift clocks below cannot glitch.
    // ------------------------------------------------------------------
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            update_ir_q <= 1'b0;
            update_dr_q <= 1'b0;
            ir_en       <= 1'b0;
            dr_en       <= 1'b0;
            tdo_q       <= 1'b0;
            tdo_en_q    <= 1'b0;
        end else begin
            update_ir_q <= (cur == UPDATE_IR);
            update_dr_q <= (cur == UPDATE_DR);
            ir_en       <= (cur == CAPTURE_IR) || (cur == SHIFT_IR);
            dr_en       <= (cur == CAPTURE_DR) || (cur == SHIFT_DR);
            // TLR reached through tms presents the same quiet outputs as trst
            tdo_q       <= (cur == TLR) ? 1'b0 : (sel ? bus.tdo_ir : bus.tdo_dr);
            tdo_en_q    <= (cur == SHIFT_IR) || (cur == SHIFT_DR);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.state     = cur;
    assign bus.tl_reset  = (cur != TLR);
    assign bus.captureIR = (cur == CAPTURE_IR);
    assign bus.shiftIR   = (cur == SHIFT_IR);
    assign bus.captureDR = (cur == CAPTURE_DR);
    assign bus.shiftDR   = (cur == SHIFT_DR);
    assign bus.select    = sel;
    assign bus.updateIR  = update_ir_q;
    assign bus.updateDR  = update_dr_q;
    assign bus.tck_ir    = tck & ir_en;
    assign bus.tck_dr    = tck & dr_en;
    assign bus.tdo       = tdo_q;
    assign bus.tdo_en    = tdo_en_q;

endmodule

// File: tb/tb_tap_controller.sv
// ----------------------------------------------------------------------------
// tb_tap_controller
// Directed stimulus for tap_controller. Each step pushes its hand-computed
// expectation into a queue; a separate monitor pops and compares against the
// DUT outputs and against edge/pulse counters observed on the DUT outputs.
// ----------------------------------------------------------------------------
module tb_tap_controller;

    logic tck;
    logic trst;

    tap_controller_if bus ();

    tap_controller dut (
        .tck  (tck),
        .trst (trst),
        .bus  (bus)
    );

    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    // Output vector bit positions
    localparam logic [15:0] M_STATE = 16'hF000;
    localparam logic [15:0] M_TLR   = 16'h0800;
    localparam logic [15:0] M_CIR   = 16'h0400;
    localparam logic [15:0] M_SIR   = 16'h0200;
    localparam logic [15:0] M_CDR   = 16'h0100;
    localparam logic [15:0] M_SDR   = 16'h0080;
    localparam logic [15:0] M_UIR   = 16'h0040;
    localparam logic [15:0] M_UDR   = 16'h0020;
    localparam logic [15:0] M_TIR   = 16'h0010;
    localparam logic [15:0] M_TDR   = 16'h0008;
    localparam logic [15:0] M_SEL   = 16'h0004;
    localparam logic [15:0] M_TDO   = 16'h0002;
    localparam logic [15:0] M_TEN   = 16'h0001;

    localparam int K_VEC  = 0;
    localparam int K_IRE  = 1;
    localparam int K_DRE  = 2;
    localparam int K_UIR  = 3;
    localparam int K_UDR  = 4;
    localparam int K_MARK = 5;
    localparam int K_DONE = 9;

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] mask;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];
    event push_ev;

    int tests = 0;
    int fails = 0;

    // Edge / pulse counters on DUT outputs
    int ir_edges  = 0;
    int dr_edges  = 0;
    int uir_puls  = 0;
    int udr_puls  = 0;

    always @(posedge bus.tck_ir)   ir_edges <= ir_edges + 1;
    always @(posedge bus.tck_dr)   dr_edges <= dr_edges + 1;
    always @(posedge bus.updateIR) uir_puls <= uir_puls + 1;
    always @(posedge bus.updateDR) udr_puls <= udr_puls + 1;

    function automatic logic [15:0] out_vec();
        return {bus.state, bus.tl_reset, bus.captureIR, bus.shiftIR,
                bus.captureDR, bus.shiftDR, bus.updateIR, bus.updateDR,
                bus.tck_ir, bus.tck_dr, bus.select, bus.tdo, bus.tdo_en};
    endfunction

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin : monitor
        exp_t e;
        int   act;
        int   b_ir, b_dr, b_uir, b_udr;
        logic [15:0] v;
        b_ir = 0; b_dr = 0; b_uir = 0; b_udr = 0;
        forever begin
            @(push_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.kind)
                    K_VEC: begin
                        tests++;
                        v = out_vec();
                        if ((v & e.mask) !== (e.val & e.mask)) begin
                            fails++;
                            $display("FAIL %s: got %h required %h (mask %h)",
                                     e.name, v & e.mask, e.val & e.mask, e.mask);
                        end
                    end
                    K_IRE, K_DRE, K_UIR, K_UDR: begin
                        tests++;
                        case (e.kind)
                            K_IRE:   act = ir_edges - b_ir;
                            K_DRE:   act = dr_edges - b_dr;
                            K_UIR:   act = uir_puls - b_uir;
                            default: act = udr_puls - b_udr;
                        endcase
                        if (act != int'(e.val)) begin
                            fails++;
                            $display("FAIL %s: got %0d required %0d",
                                     e.name, act, e.val);
                        end
                    end
                    K_MARK: begin
                        b_ir  = ir_edges;
                        b_dr  = dr_edges;
                        b_uir = uir_puls;
                        b_udr = udr_puls;
                    end
                    default: begin
                        $display("[TB] %0d tests run, %0d failed", tests, fails);
                        $finish;
                    end
                endcase
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all steps start and end at falling edge + 1)
    // ------------------------------------------------------------------
    task automatic push(input string n, input int k, input logic [15:0] m,
                        input logic [15:0] v);
        exp_t e;
        e.name = n; e.kind = k; e.mask = m; e.val = v;
        exp_q.push_back(e);
        -> push_ev;
        #0;
    endtask

    task automatic chk(input string n, input logic [15:0] m, input logic [3:0] st,
                       input logic [15:0] bits);
        push(n, K_VEC, m, {st, 12'h000} | bits);
    endtask

    task automatic chk_state(input string n, input logic [3:0] st);
        chk(n, M_STATE, st, 16'h0000);
    endtask

    task automatic chk_cnt(input string n, input int k, input int cnt);
        push(n, k, 16'h0000, 16'(cnt));
    endtask

    task automatic mark();
        push("mark", K_MARK, 16'h0000, 16'h0000);
    endtask

    task automatic tick(input logic b);
        bus.tms = b;
        @(posedge tck);
        #1;
        @(negedge tck);
        #1;
    endtask

    localparam logic [15:0] M_ALL = 16'hFFFF;

    initial begin : stimulus
        trst       = 1'b0;
        bus.tms    = 1'b1;
        bus.tdo_ir = 1'b0;
        bus.tdo_dr = 1'b1;
        @(negedge tck);
        #1;
        // Asynchronous reset: TLR, everything quiet
        chk("reset_all", M_ALL, 4'hF, 16'h0000);

        // First transition after release uses tms
        trst = 1'b1;
        tick(1'b0);
        chk("rel_idle", M_STATE | M_TLR, 4'hC, M_TLR);

        // TLR-path IR scan: C,7,4,E,A,A,9 with 3 tck_ir edges
        bus.tdo_ir = 1'b1;
        bus.tdo_dr = 1'b0;
        mark();
        tick(1'b1); chk_state("seq_sel_dr", 4'h7);
        tick(1'b1); chk("seq_sel_ir", M_STATE | M_SEL, 4'h4, M_SEL);
        tick(1'b0); chk("seq_cap_ir", M_STATE | M_CIR | M_SIR | M_SEL | M_TLR | M_TEN,
                        4'hE, M_CIR | M_SEL | M_TLR);
        tick(1'b0); chk("seq_shift_ir", M_STATE | M_SIR | M_CIR | M_SEL | M_TDO | M_TEN | M_TIR,
                        4'hA, M_SIR | M_SEL | M_TDO | M_TEN);
        tick(1'b0); chk_state("seq_shift_ir2", 4'hA);
        tick(1'b1); chk("seq_exit1_ir", M_STATE | M_TEN | M_SIR, 4'h9, 16'h0000);
        chk_cnt("tck_ir_edges_3", K_IRE, 3);
        chk_cnt("tck_dr_edges_0", K_DRE, 0);

        // Exit1-IR -> Update-IR -> Run-Idle: one updateIR pulse
        mark();
        tick(1'b1); chk("upd_ir_high", M_STATE | M_UIR | M_UDR | M_TIR, 4'hD, M_UIR);
        tick(1'b0); chk("upd_ir_low", M_STATE | M_UIR, 4'hC, 16'h0000);
        chk_cnt("upd_ir_pulses_1", K_UIR, 1);

        // Mid-cycle tms change has no effect before the next rising edge
        bus.tms = 1'b0;
        @(posedge tck);
        #2;
        bus.tms = 1'b1;
        @(negedge tck);
        #1;
        chk_state("tms_midcycle", 4'hC);
        tick(1'b1); chk_state("tms_next_edge", 4'h7);

        // Shift-IR then five tms=1: 9, D, 7, 4, F with one updateIR pulse
        tick(1'b1);
        tick(1'b0);
        tick(1'b0); chk_state("five_start_shift_ir", 4'hA);
        bus.tdo_dr = 1'b1;
        mark();
        tick(1'b1); chk_state("five_9", 4'h9);
        tick(1'b1); chk("five_D", M_STATE | M_UIR, 4'hD, M_UIR);
        tick(1'b1); chk("five_7", M_STATE | M_UIR, 4'h7, 16'h0000);
        tick(1'b1); chk_state("five_4", 4'h4);
        tick(1'b1); chk("five_F_tlr", M_ALL, 4'hF, 16'h0000);
        chk_cnt("five_uir_pulses_1", K_UIR, 1);

        // Shift-DR serial out selection and tdo_en drop on exit
        bus.tdo_ir = 1'b0;
        bus.tdo_dr = 1'b1;
        tick(1'b0);
        tick(1'b1);
        tick(1'b0); chk("cap_dr", M_STATE | M_CDR | M_SEL | M_TEN, 4'h6, M_CDR);
        tick(1'b0); chk("shift_dr", M_STATE | M_SDR | M_SEL | M_TDO | M_TEN,
                        4'h2, M_SDR | M_TDO | M_TEN);
        tick(1'b1); chk("exit1_dr_ten", M_STATE | M_TEN | M_SDR, 4'h1, 16'h0000);

        // Pause-DR hold: no tck_dr edges, no updateDR
        mark();
        tick(1'b0);
        for (int unsigned i = 0; i < 4; i++) begin
            tick(1'b0);
            chk("pause_dr_hold", M_STATE | M_UDR | M_TDR, 4'h3, 16'h0000);
        end
        chk_cnt("pause_dr_edges_0", K_DRE, 0);
        chk_cnt("pause_udr_0", K_UDR, 0);

        // trst during Shift-DR with tck low
        tick(1'b1); chk_state("exit2_dr", 4'h0);
        tick(1'b0);
        tick(1'b0); chk("shift_dr_again", M_STATE | M_TEN, 4'h2, M_TEN);
        mark();
        trst = 1'b0;
        #1;
        chk("trst_in_shift", M_STATE | M_TLR | M_TEN | M_TDR | M_UDR, 4'hF, 16'h0000);
        @(negedge tck);
        @(negedge tck);
        #1;
        chk_cnt("trst_shift_dr_edges_0", K_DRE, 0);
        chk_cnt("trst_shift_udr_0", K_UDR, 0);

        // trst during Update-DR kills the strobe immediately
        trst = 1'b1;
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        tick(1'b1); chk("upd_dr_high", M_STATE | M_UDR, 4'h5, M_UDR);
        mark();
        trst = 1'b0;
        #1;
        chk("trst_in_update", M_STATE | M_UDR | M_TLR, 4'hF, 16'h0000);
        @(negedge tck);
        @(negedge tck);
        #1;
        chk_cnt("trst_upd_udr_0", K_UDR, 0);
        chk("trst_held", M_ALL, 4'hF, 16'h0000);

        // Pause-IR, then five tms=1 reach TLR
        trst = 1'b1;
        tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        tick(1'b0); chk("pause_ir", M_STATE | M_SEL | M_TIR, 4'hB, M_SEL);
        tick(1'b1); chk_state("pir_8", 4'h8);
        tick(1'b1); chk_state("pir_D", 4'hD);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1); chk("pir_tlr", M_ALL, 4'hF, 16'h0000);

        push("done", K_DONE, 16'h0000, 16'h0000);
    end

endmodule

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 The block SHALL have no parameters and SHALL use the IEEE 1149.1 4-bit state encoding given in REQ-014.
REQ-002 tck  input  1  test clock; the only clock, with the FSM on the rising edge and output retiming on the falling edge.
REQ-003 trst  input  1  asynchronous, active-low reset.
REQ-004 tms  input  1  test mode select, sampled on rising tck.
REQ-005 tdo_ir  input  1  serial out of the instruction register.
REQ-006 tdo_dr  input  1  serial out of the selected data register.
REQ-007 state  output  4  current TAP state.
REQ-008 tl_reset  output  1  active-low test-logic reset to the IR and DRs.
REQ-009 captureIR, shiftIR, captureDR, shiftDR  output  1 each  state-decode levels.
REQ-010 updateIR, updateDR  output  1 each  update strobes; each is a clean edge source.
REQ-011 tck_ir, tck_dr  output  1 each  gated tck for the IR and DR shift chains.
REQ-012 select  output  1  1 = IR path, 0 = DR path.
REQ-013 tdo, tdo_en  output  1 each  retimed serial out and its output enable.

Function
REQ-014 Encoding SHALL be:
- Exit2-DR=0, Exit1-DR=1, Shift-DR=2, Pause-DR=3.
- Select-IR=4, Update-DR=5, Capture-DR=6, Select-DR=7.
- Exit2-IR=8, Exit1-IR=9, Shift-IR=A, Pause-IR=B.
- Run-Idle=C, Update-IR=D, Capture-IR=E, Test-Logic-Reset (TLR)=F.
REQ-015 Transitions on rising tck, given as (tms=0 / tms=1):
- TLR: Run-Idle / TLR; Run-Idle: Run-Idle / Select-DR.
- Select-DR: Capture-DR / Select-IR; Select-IR: Capture-IR / TLR.
- Capture-x: Shift-x / Exit1-x; Shift-x: Shift-x / Exit1-x.
- Exit1-x: Pause-x / Update-x; Pause-x: Pause-x / Exit2-x.
- Exit2-x: Shift-x / Update-x; Update-x: Run-Idle / Select-DR.
REQ-016 From any state, five consecutive rising tck edges with tms=1 SHALL reach TLR.
REQ-017 tl_reset SHALL be combinational: 0 exactly while state==F, otherwise 1.
REQ-018 captureIR, shiftIR, captureDR and shiftDR SHALL be combinational decodes of state E, A, 6 and 2 respectively.
REQ-019 select SHALL be 1 in states 4, 8, 9, A, B, D and E, and 0 otherwise.
REQ-020 updateIR SHALL be registered on falling tck as (state==D).
- It therefore rises at the falling edge inside Update-IR and falls at the next falling edge.
- Width is one tck period, with no glitches.
REQ-021 updateDR SHALL follow the same rule as REQ-020 for state 5.
REQ-022 The IR clock enable SHALL be latched on falling tck as state in {E, A}, and tck_ir SHALL equal tck AND that enable.
- This gives exactly one tck_ir rising edge at the end of each Capture-IR and each Shift-IR cycle.
REQ-023 tck_dr SHALL follow the same rule as REQ-022 using states {6, 2}.
REQ-024 In Pause, Exit and Update states, tck_ir and tck_dr SHALL stay low.
REQ-025 On falling tck, tdo SHALL be registered as (select ? tdo_ir : tdo_dr), and tdo_en SHALL be registered as state in {A, 2}.
REQ-026 tdo_en SHALL drop at the first falling edge after leaving a Shift state.
REQ-027 A tms change mid-cycle SHALL have no effect until the next rising tck.

Reset
REQ-028 When trst=0, the block SHALL asynchronously force:
- state=F and tl_reset=0;
- updateIR=0, updateDR=0, tdo=0, tdo_en=0;
- both clock enables=0, so tck_ir=0 and tck_dr=0.
REQ-029 trst asserted mid-operation, including mid-shift or in an Update state, SHALL abort with no further update strobe or gated clock edge.
REQ-030 After trst deasserts, the first transition SHALL occur on the next rising tck using tms.
REQ-031 The TLR state entered via tms SHALL produce the same output values as REQ-028.

Verification
REQ-032 trst=0 while in Shift-DR with tck low -> immediately state=F, tl_reset=0, tdo_en=0, tck_dr=0, and no updateDR pulse.
REQ-033 From Shift-IR, tms=1 for 5 tck -> state sequence 9, D, 7, 4, F, and exactly one updateIR pulse during D.
REQ-034 From TLR, tms=0,1,1,0,0,0,1 -> states C, 7, 4, E, A, A, 9, with captureIR=1 in E and exactly 3 tck_ir rising edges.
REQ-035 From Exit1-IR, tms=1 then 0 -> updateIR rises at the falling edge in D, falls one period later, and state=C.
REQ-036 In Shift-DR with tdo_dr=1 and tdo_ir=0 -> tdo=1 and tdo_en=1 after the falling edge; on exit to 1, tdo_en=0 at the next falling edge.
REQ-037 Holding Pause-DR with tms=0 for 4 tck -> state stays 3, with no tck_dr edges and updateDR=0.
